// File: rtl/processor_pkg.sv
// Shared definitions for the program loader: FSM state encoding and the
// default frame start marker.
package processor_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_CNT_HI,
        ST_CNT_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } loader_state_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/loader_timeout_counter.sv
// Inter-byte gap counter: counts idle cycles while enabled and flags expiry
// once the count reaches TIMEOUT_CYCLES.
module loader_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] gap_cnt;

    // Saturates at the limit so expiry stays asserted until cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gap_cnt <= '0;
        end else if (clr) begin
            gap_cnt <= '0;
        end else if (en && gap_cnt != LIMIT) begin
            gap_cnt <= gap_cnt + 16'd1;
        end
    end

    assign expired = (gap_cnt == LIMIT);

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader for the fetch stage instruction memory: parses
// SYNC/ADDR/CNT/DATA/CHK frames, writes 16-bit words and gates the fetch reset.
module program_loader
    import processor_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         MAX_WORDS      = 1024,
    parameter int         TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        write_enable_fm,
    output logic [15:0] write_data_fm,
    output logic [31:0] write_addr_fm,
    output logic        rst_fm,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_written
);

    localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

    loader_state_e state, state_nxt;

    logic        accept;
    logic        in_frame;
    logic        timed_out;
    logic        sync_start;
    logic        last_word;
    logic [15:0] count_asm;
    logic [7:0]  addr_hi_q;
    logic [7:0]  cnt_hi_q;
    logic [7:0]  data_hi_q;
    logic [7:0]  chk_q;
    logic [15:0] base_q;
    logic [15:0] word_cnt_q;

    assign accept     = byte_valid & byte_ready;
    assign in_frame   = !(state inside {ST_IDLE, ST_DONE, ST_ERROR});
    assign sync_start = accept && !in_frame && (byte_data == SYNC_BYTE);
    assign count_asm  = {cnt_hi_q, byte_data};
    assign last_word  = ((words_written + 16'd1) == word_cnt_q);

    loader_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clr    (!in_frame || accept),
        .en     (in_frame),
        .expired(timed_out)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A stalled frame aborts even if a byte arrives on the expiry cycle.
    always_comb begin
        state_nxt = state;
        if (in_frame && timed_out) begin
            state_nxt = ST_ERROR;
        end else if (accept) begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (byte_data == SYNC_BYTE) state_nxt = ST_ADDR_HI;
                end
                ST_ADDR_HI: state_nxt = ST_ADDR_LO;
                ST_ADDR_LO: state_nxt = ST_CNT_HI;
                ST_CNT_HI:  state_nxt = ST_CNT_LO;
                ST_CNT_LO: begin
                    if (count_asm > MAX_CNT)    state_nxt = ST_ERROR;
                    else if (count_asm == 16'd0) state_nxt = ST_CHECK;
                    else                         state_nxt = ST_DATA_HI;
                end
                ST_DATA_HI: state_nxt = ST_DATA_LO;
                ST_DATA_LO: state_nxt = last_word ? ST_CHECK : ST_DATA_HI;
                ST_CHECK:   state_nxt = (byte_data == chk_q) ? ST_DONE : ST_ERROR;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    // Header and high-byte capture; only meaningful inside a frame.
    always_ff @(posedge clk) begin
        if (accept) begin
            case (state)
                ST_ADDR_HI: addr_hi_q  <= byte_data;
                ST_ADDR_LO: base_q     <= {addr_hi_q, byte_data};
                ST_CNT_HI:  cnt_hi_q   <= byte_data;
                ST_CNT_LO:  word_cnt_q <= count_asm;
                ST_DATA_HI: data_hi_q  <= byte_data;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_ready      <= 1'b0;
            rst_fm          <= 1'b1;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            words_written   <= '0;
            chk_q           <= '0;
            write_enable_fm <= 1'b0;
            write_data_fm   <= '0;
            write_addr_fm   <= '0;
        end else begin
            byte_ready      <= 1'b1;
            write_enable_fm <= 1'b0;
            if (sync_start) begin
                done          <= 1'b0;
                error         <= 1'b0;
                words_written <= '0;
                chk_q         <= '0;
                busy          <= 1'b1;
                rst_fm        <= 1'b1;
            end
            if (accept && in_frame && state != ST_CHECK) begin
                chk_q <= chk_q ^ byte_data;
            end
            if (accept && state == ST_DATA_LO && !timed_out) begin
                write_enable_fm <= 1'b1;
                write_data_fm   <= {data_hi_q, byte_data};
                write_addr_fm   <= {16'h0000, base_q} + {16'h0000, words_written};
                words_written   <= words_written + 16'd1;
            end
            if (state_nxt == ST_ERROR && state != ST_ERROR) begin
                busy  <= 1'b0;
                error <= 1'b1;
            end
            if (state_nxt == ST_DONE && state != ST_DONE) begin
                busy   <= 1'b0;
                done   <= 1'b1;
                rst_fm <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed and randomized frame bench for program_loader, checked against a
// frame-level model of the expected writes and final status.
module tb_program_loader;

    localparam int TO   = 200;
    localparam int MAXW = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        write_enable_fm;
    logic [15:0] write_data_fm;
    logic [31:0] write_addr_fm;
    logic        rst_fm;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_written;

    int checks = 0;
    int failures = 0;

    logic [47:0] obs_q[$];
    logic [15:0] frame_words[$];

    program_loader #(
        .SYNC_BYTE     (8'hA5),
        .MAX_WORDS     (MAXW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .byte_valid     (byte_valid),
        .byte_data      (byte_data),
        .byte_ready     (byte_ready),
        .write_enable_fm(write_enable_fm),
        .write_data_fm  (write_data_fm),
        .write_addr_fm  (write_addr_fm),
        .rst_fm         (rst_fm),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .words_written  (words_written)
    );

    always #5 clk = ~clk;

    // Every strobe cycle is logged; a stuck strobe shows up as extra entries.
    always @(negedge clk) begin
        if (write_enable_fm) obs_q.push_back({write_addr_fm, write_data_fm});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    // Sends SYNC, header, frame_words and checksum (xor chk_xor), then
    // compares the logged writes and final status with the frame model.
    task automatic send_frame(input logic [15:0] base, input logic [7:0] chk_xor,
                              input int max_gap, input string tag);
        logic [7:0]  b[$];
        logic [7:0]  chk;
        logic [15:0] n16;
        logic [47:0] exp_w;
        int          n;
        bit          ok;
        n   = frame_words.size();
        n16 = 16'(n);
        b = {8'hA5, base[15:8], base[7:0], n16[15:8], n16[7:0]};
        foreach (frame_words[i]) begin
            b.push_back(frame_words[i][15:8]);
            b.push_back(frame_words[i][7:0]);
        end
        chk = 8'h00;
        for (int i = 1; i < b.size(); i++) chk = chk ^ b[i];
        b.push_back(chk ^ chk_xor);
        ok = (chk_xor == 8'h00);
        obs_q.delete();
        foreach (b[i]) begin
            send_byte(b[i]);
            if (i == 0) begin
                check({tag, "_busy_start"}, {63'd0, busy}, 64'd1);
                check({tag, "_done_start"}, {63'd0, done}, 64'd0);
            end
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
        idle(2);
        check({tag, "_nwrites"}, 64'(obs_q.size()), 64'(n));
        for (int i = 0; i < n && i < obs_q.size(); i++) begin
            exp_w = {32'(base) + 32'(i), frame_words[i]};
            check({tag, "_write"}, 64'(obs_q[i]), 64'(exp_w));
        end
        check({tag, "_done"},   {63'd0, done},   {63'd0, ok});
        check({tag, "_error"},  {63'd0, error},  {63'd0, !ok});
        check({tag, "_rst_fm"}, {63'd0, rst_fm}, {63'd0, !ok});
        check({tag, "_busy"},   {63'd0, busy},   64'd0);
        check({tag, "_words"},  64'(words_written), 64'(n));
    endtask

    initial begin
        #2 reset = 1'b0;
        #2;
        check("rst_fm_rst",  {63'd0, rst_fm}, 64'd1);
        check("ready_rst",   {63'd0, byte_ready}, 64'd0);
        check("busy_rst",    {63'd0, busy}, 64'd0);
        check("done_rst",    {63'd0, done}, 64'd0);
        check("error_rst",   {63'd0, error}, 64'd0);
        check("we_rst",      {63'd0, write_enable_fm}, 64'd0);
        check("words_rst",   64'(words_written), 64'd0);
        check("addr_rst",    64'(write_addr_fm), 64'd0);
        idle(2);
        reset = 1'b1;
        idle(2);
        check("ready_after_rst", {63'd0, byte_ready}, 64'd1);

        // Directed two-word frame, correct then corrupted checksum.
        frame_words = {16'h1234, 16'hABCD};
        send_frame(16'h0010, 8'h00, 0, "dirA");
        send_frame(16'h0010, 8'h01, 0, "dirA_bad");

        // Oversized count is rejected right after CNT_LO.
        obs_q.delete();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h04); send_byte(8'h01);
        check("big_error_now", {63'd0, error}, 64'd1);
        idle(2);
        check("big_error",  {63'd0, error}, 64'd1);
        check("big_done",   {63'd0, done}, 64'd0);
        check("big_rst_fm", {63'd0, rst_fm}, 64'd1);
        check("big_nwrites", 64'(obs_q.size()), 64'd0);

        // Empty frame.
        frame_words.delete();
        send_frame(16'h0000, 8'h00, 0, "zero");

        // Stall after DATA_HI until the gap timer expires.
        obs_q.delete();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h20);
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h34);
        idle(TO - 1);
        check("to_not_yet", {63'd0, error}, 64'd0);
        check("to_busy",    {63'd0, busy}, 64'd1);
        idle(3);
        check("to_error",   {63'd0, error}, 64'd1);
        check("to_rst_fm",  {63'd0, rst_fm}, 64'd1);
        check("to_busy_end", {63'd0, busy}, 64'd0);
        check("to_nwrites", 64'(obs_q.size()), 64'd0);
        frame_words = {16'hA5A5, 16'h0001, 16'hFFFF};
        send_frame(16'h0100, 8'h00, 0, "recover");

        // Garbage, then reset mid-data.
        obs_q.delete();
        send_byte(8'h00); send_byte(8'hFF);
        check("garbage_busy", {63'd0, busy}, 64'd0);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h40);
        send_byte(8'h00); send_byte(8'h04);
        send_byte(8'h11); send_byte(8'h11); send_byte(8'h22);
        reset = 1'b0;
        #1;
        check("arst_rst_fm", {63'd0, rst_fm}, 64'd1);
        check("arst_busy",   {63'd0, busy}, 64'd0);
        check("arst_ready",  {63'd0, byte_ready}, 64'd0);
        check("arst_words",  64'(words_written), 64'd0);
        check("arst_data",   64'(write_data_fm), 64'd0);
        byte_valid = 1'b1;
        byte_data  = 8'h22;
        idle(3);
        byte_valid = 1'b0;
        reset = 1'b1;
        idle(3);
        check("arst_nwrites", 64'(obs_q.size()), 64'd1);
        check("arst_first",   64'(obs_q[0]), 64'({32'h0000_0040, 16'h1111}));
        check("arst_done",    {63'd0, done}, 64'd0);
        frame_words = {16'hBEEF, 16'hCAFE};
        send_frame(16'h0200, 8'h00, 0, "post_rst");

        // Randomized frames with random gaps and occasional bad checksums.
        for (int f = 0; f < 8; f++) begin
            logic [15:0] base;
            logic [7:0]  cx;
            int          n;
            base = (f == 3) ? 16'hFFFE : 16'($urandom);
            n = $urandom_range(1, 8);
            frame_words.delete();
            for (int i = 0; i < n; i++) begin
                frame_words.push_back(($urandom_range(0, 4) == 0) ? 16'hA5A5 : 16'($urandom));
            end
            cx = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            send_frame(base, cx, 3, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the fetch module's instruction-memory load port: drives `write_enable_fm`, `write_data_fm`, `write_addr_fm` and `rst_fm` of `fetchInstructionModule`.
- Receives a framed byte stream over a valid/ready handshake from a host link (UART bridge or testbench).
- Assembles big-endian 16-bit instruction words and writes them to consecutive addresses.
- Holds the fetch stage in reset until a frame completes with a correct checksum.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker
- MAX_WORDS, 1024, largest accepted word count; a larger count is an error
- TIMEOUT_CYCLES, 65535, maximum idle cycles between bytes inside a frame

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- byte_valid  input  1  host byte available
- byte_data  input  8  host byte
- byte_ready  output  1  loader can accept a byte; transfer occurs when byte_valid & byte_ready
- write_enable_fm  output  1  one-cycle instruction-memory write strobe
- write_data_fm  output  16  instruction word
- write_addr_fm  output  32  word address, zero-extended
- rst_fm  output  1  active-high fetch-stage reset; held high while not loaded
- busy  output  1  a frame is in progress
- done  output  1  last frame loaded successfully
- error  output  1  last frame rejected
- words_written  output  16  count of writes issued in the current or last frame

Behaviour:
- Reset (reset=0, asynchronous) values: state IDLE, rst_fm=1, write_enable_fm=0, write_data_fm=0, write_addr_fm=0, busy=0, done=0, error=0, words_written=0, byte_ready=0. After release, byte_ready=1 in every state.
- Frame format: SYNC, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then CNT × (DATA_HI, DATA_LO), then CHK. CHK = XOR of every byte after SYNC.
- State sequence: IDLE → ADDR_HI → ADDR_LO → CNT_HI → CNT_LO → DATA_HI ⇄ DATA_LO → CHECK → DONE | ERROR. Each transition happens on an accepted byte.
- IDLE, DONE, ERROR:
  - An accepted SYNC_BYTE enters ADDR_HI on the next cycle.
  - On that same cycle: clear done, error, words_written and the running checksum; set busy=1 and rst_fm=1.
  - Any other byte is consumed and dropped with no state change.
- CNT_LO:
  - If the assembled count > MAX_WORDS → ERROR.
  - Else if count == 0 → CHECK.
  - Else → DATA_HI.
- DATA_LO accept triggers a write on the following cycle:
  - write_enable_fm=1 for exactly one cycle.
  - write_data_fm = {hi, lo}.
  - write_addr_fm = base + words_written (32-bit add; base is zero-extended).
  - words_written then increments.
  - data/addr hold their last values afterwards.
- Back-to-back bytes are accepted every cycle; the write pipeline never stalls byte_ready.
- After the word with index CNT-1, the next state is CHECK.
- CHECK byte:
  - Matches the running XOR → DONE: busy=0, done=1, rst_fm=0 on the cycle after acceptance.
  - Mismatch → ERROR: busy=0, error=1, rst_fm stays 1.
- Words already written in a failed frame are not rolled back.
- Timeout: in any state other than IDLE/DONE/ERROR, a 16-bit gap counter increments on each cycle without an accepted byte and clears on acceptance. Reaching TIMEOUT_CYCLES → ERROR.
- A SYNC_BYTE value arriving mid-frame is treated as ordinary data; there is no resync.
- Reset asserted mid-frame aborts immediately: no further writes, rst_fm=1.
- done and error are never both 1.

Decomposition:
- Shared package (processor_pkg) holds the loader state encoding (enum) and the SYNC_BYTE default.
- One natural sub-module: loader_timeout_counter, holding the gap counter with clear/enable and an expiry flag.
- Frame FSM, word assembly, checksum and write register stay in program_loader.

Test Plan:
- Frame A5, 00 10, 00 02, 12 34, AB CD, CHK=0x10^0x02^0x12^0x34^0xAB^0xCD → writes 0x1234@0x10 and 0xABCD@0x11, each a single strobe; done=1, rst_fm=0, words_written=2.
- Same frame with CHK xor 0x01 → both writes still occur; error=1, done=0, rst_fm=1.
- Count 0x0401 (> MAX_WORDS) → ERROR right after CNT_LO; no write strobe.
- Count 0 frame (A5 00 00 00 00 00) → done=1, no writes.
- Stall of TIMEOUT_CYCLES after DATA_HI → error=1, rst_fm=1. A subsequent valid frame recovers to done=1.
- Garbage bytes 00 FF before A5, then reset pulsed low mid-data → outputs return to reset values asynchronously, no further strobes. A new frame loads correctly.
